// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU op codes
// (also decoded by aludec) and the divider state encoding.
package hilo_muldiv_unit_pkg;

    localparam logic [7:0] ALU_MFHI  = 8'h10;
    localparam logic [7:0] ALU_MTHI  = 8'h11;
    localparam logic [7:0] ALU_MFLO  = 8'h12;
    localparam logic [7:0] ALU_MTLO  = 8'h13;
    localparam logic [7:0] ALU_MULT  = 8'h18;
    localparam logic [7:0] ALU_MULTU = 8'h19;
    localparam logic [7:0] ALU_DIV   = 8'h1A;
    localparam logic [7:0] ALU_DIVU  = 8'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_div_radix2.sv
// Iterative radix-2 restoring divider working on magnitudes, with the sign
// of quotient/remainder restored combinationally once the iterations finish.
module div_radix2
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      divisor_q, divisor_d;
    logic [31:0]      rem_q, rem_d;
    logic [31:0]      quo_q, quo_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    logic [32:0]      rem_sh;
    logic             fits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        // The dividend shifts out of the quotient register into the 33-bit
        // partial remainder; bit 32 set means it certainly exceeds the divisor.
        rem_sh    = {rem_q, quo_q[31]};
        fits      = rem_sh[32] | (rem_sh[31:0] >= divisor_q);

        case (state_q)
            DIV_IDLE: begin
                if (start) begin
                    divisor_d = signed_op ? abs32(b) : b;
                    quo_d     = signed_op ? abs32(a) : a;
                    rem_d     = '0;
                    negq_d    = signed_op & (a[31] ^ b[31]);
                    negr_d    = signed_op & a[31];
                    cnt_d     = '0;
                    state_d   = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (abort) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = fits ? (rem_sh[31:0] - divisor_q) : rem_sh[31:0];
                    quo_d = {quo_q[30:0], fits};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = DIV_DONE;
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    assign busy      = ((state_q == DIV_IDLE) && start) || (state_q == DIV_BUSY);
    assign done      = (state_q == DIV_DONE) && !abort;
    assign quotient  = negq_q ? (~quo_q + 32'd1) : quo_q;
    assign remainder = negr_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: owns HI/LO, single-cycle multiply, MTxx/MFxx,
// and an iterative divider that stalls E while it runs.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int DIV_ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  alucontrolE,
    input  logic        hilowriteE,
    input  logic        flushE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    output logic        stallE,
    output logic [31:0] hilo_rdataE,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        wr_en;
    logic        div_start;
    logic        div_signed;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_quo;
    logic [31:0] div_rem;
    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Gating with rst keeps stallE low while reset is asserted, even if a
    // divide op is still presented on the E inputs.
    assign wr_en      = rst & hilowriteE & ~flushE;
    assign div_start  = wr_en & ((alucontrolE == ALU_DIV) | (alucontrolE == ALU_DIVU));
    assign div_signed = (alucontrolE == ALU_DIV);

    assign prod_s = $signed({{32{srcaE[31]}}, srcaE}) * $signed({{32{srcbE[31]}}, srcbE});
    assign prod_u = {32'd0, srcaE} * {32'd0, srcbE};

    div_radix2 #(
        .DIV_ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst),
        .start     (div_start),
        .signed_op (div_signed),
        .a         (srcaE),
        .b         (srcbE),
        .abort     (flushE),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quo;
        end else if (wr_en) begin
            case (alucontrolE)
                ALU_MULT:  {hi_d, lo_d} = prod_s;
                ALU_MULTU: {hi_d, lo_d} = prod_u;
                ALU_MTHI:  hi_d = srcaE;
                ALU_MTLO:  lo_d = srcaE;
                default:   ;
            endcase
        end
    end

    always_comb begin
        hilo_rdataE = '0;
        case (alucontrolE)
            ALU_MFHI: hilo_rdataE = hi_q;
            ALU_MFLO: hilo_rdataE = lo_q;
            default:  ;
        endcase
    end

    assign stallE = div_busy;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Self-checking bench for hilo_muldiv_unit using a HI/LO scoreboard queue.
module tb_hilo_muldiv_unit;
    import hilo_muldiv_unit_pkg::*;

    localparam logic [7:0] NOP = 8'h00;
    localparam int DIV_STALL = 33;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  alucontrolE;
    logic        hilowriteE;
    logic        flushE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        stallE;
    logic [31:0] hilo_rdataE;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.DIV_ITERS(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .alucontrolE (alucontrolE),
        .hilowriteE  (hilowriteE),
        .flushE      (flushE),
        .srcaE       (srcaE),
        .srcbE       (srcbE),
        .stallE      (stallE),
        .hilo_rdataE (hilo_rdataE),
        .hi_o        (hi_o),
        .lo_o        (lo_o)
    );

    function automatic logic [63:0] ref_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sbv;
        sa  = $signed(a);
        sbv = $signed(b);
        if (sgn) return sa * sbv;
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sbv;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = (sgn && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa  = $signed(a);
            sbv = $signed(b);
            q = 32'(sa / sbv);
            r = 32'(sa % sbv);
        end
        return {r, q};
    endfunction

    task automatic drive(input logic [7:0] op, input logic hw, input logic fl,
                         input logic [31:0] a, input logic [31:0] b);
        alucontrolE = op;
        hilowriteE  = hw;
        flushE      = fl;
        srcaE       = a;
        srcbE       = b;
    endtask

    // Single-cycle write op (MULT/MULTU/MTHI/MTLO); called at posedge+1.
    task automatic do_write(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        case (op)
            ALU_MULT:  {m_hi, m_lo} = ref_mul(1'b1, a, b);
            ALU_MULTU: {m_hi, m_lo} = ref_mul(1'b0, a, b);
            ALU_MTHI:  m_hi = a;
            ALU_MTLO:  m_lo = a;
            default:   ;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        drive(op, 1'b1, 1'b0, a, b);
        @(negedge clk);
        n_cmp++;
        if (stallE !== 1'b0) begin
            n_fail++;
            $display("FAIL write_nostall op=%h stallE=%b want 0", op, stallE);
        end
        @(posedge clk); #1;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL write_hilo op=%h got %h_%h want %h_%h", op, hi_o, lo_o, e.hi, e.lo);
        end
        @(posedge clk); #1;
    endtask

    // Full divide through to the write-back edge; called at posedge+1.
    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   cnt;
        {m_hi, m_lo} = ref_div(sgn, a, b);
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        drive(sgn ? ALU_DIV : ALU_DIVU, 1'b1, 1'b0, a, b);
        cnt = 0;
        @(negedge clk);
        while (stallE === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != DIV_STALL) begin
            n_fail++;
            $display("FAIL div_stall_len a=%h b=%h got %0d cycles want %0d", a, b, cnt, DIV_STALL);
        end
        @(posedge clk); #1;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL div_result sgn=%b a=%h b=%h got %h_%h want %h_%h", sgn, a, b, hi_o, lo_o, e.hi, e.lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        n_cmp++;
        if ({stallE, hi_o, lo_o, hilo_rdataE} !== 97'd0) begin
            n_fail++;
            $display("FAIL reset_state stall=%b hi=%h lo=%h rd=%h want all 0", stallE, hi_o, lo_o, hilo_rdataE);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        do_write(ALU_MULT, 32'hFFFF_FFFE, 32'd3);
        n_cmp++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
            n_fail++;
            $display("FAIL mult_const got %h_%h want ffffffff_fffffffa", hi_o, lo_o);
        end
        do_write(ALU_MULTU, 32'hFFFF_FFFE, 32'd3);
        n_cmp++;
        if ({hi_o, lo_o} !== 64'h0000_0002_FFFF_FFFA) begin
            n_fail++;
            $display("FAIL multu_const got %h_%h want 00000002_fffffffa", hi_o, lo_o);
        end
        for (int i = 0; i < 4; i++) begin
            do_write((i % 2 == 0) ? ALU_MULT : ALU_MULTU, $urandom, $urandom);
        end
    endtask

    task automatic test_mt_mf();
        exp_t e;
        do_write(ALU_MTLO, 32'hCAFE_F00D, 32'd0);
        m_hi = 32'h1234_5678;
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        drive(ALU_MTHI, 1'b1, 1'b0, 32'h1234_5678, 32'd0);
        @(posedge clk); #1;
        drive(ALU_MFHI, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (hilo_rdataE !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL mfhi_read got %h want 12345678", hilo_rdataE);
        end
        n_cmp++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL mthi_lo_kept got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
        @(posedge clk); #1;
        drive(ALU_MFLO, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (hilo_rdataE !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL mflo_read got %h want cafef00d", hilo_rdataE);
        end
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        #1;
        n_cmp++;
        if (hilo_rdataE !== 32'd0) begin
            n_fail++;
            $display("FAIL nop_read got %h want 0", hilo_rdataE);
        end
        // Writes suppressed: hilowriteE low, then flushE high
        drive(ALU_MTLO, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0);
        @(posedge clk); #1;
        drive(ALU_MULT, 1'b1, 1'b1, 32'd7, 32'd9);
        @(posedge clk); #1;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        n_cmp++;
        if ({hi_o, lo_o} !== {32'h1234_5678, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL nowrite_hold got %h_%h want 12345678_cafef00d", hi_o, lo_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div();
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2);
        n_cmp++;
        if ({hi_o, lo_o} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_neg7_2 got %h_%h want ffffffff_fffffffd", hi_o, lo_o);
        end
        do_div(1'b0, 32'd100, 32'd0);
        n_cmp++;
        if ({hi_o, lo_o} !== {32'd100, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL divu_by0 got %h_%h want 00000064_ffffffff", hi_o, lo_o);
        end
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        n_cmp++;
        if ({hi_o, lo_o} !== {32'd0, 32'h8000_0000}) begin
            n_fail++;
            $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi_o, lo_o);
        end
        do_div(1'b1, 32'hFFFF_FF9C, 32'd0);
        do_div(1'b1, 32'd17, 32'hFFFF_FFFB);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_div(i[0], $urandom, $urandom_range(1, 32'h0001_FFFF));
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cnt;
        {m_hi, m_lo} = ref_div(1'b0, 32'd1000, 32'd7);
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        drive(ALU_DIVU, 1'b1, 1'b0, 32'd1000, 32'd7);
        cnt = 0;
        @(negedge clk);
        while (stallE === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != DIV_STALL) begin
            n_fail++;
            $display("FAIL b2b_first_len got %0d want %0d", cnt, DIV_STALL);
        end
        @(posedge clk); #1;
        drive(ALU_DIV, 1'b1, 1'b0, 32'hFFFF_FC18, 32'd7);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ({stallE, hi_o, lo_o} !== {1'b1, e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL b2b_second_start got stall=%b %h_%h want stall=1 %h_%h", stallE, hi_o, lo_o, e.hi, e.lo);
        end
        {m_hi, m_lo} = ref_div(1'b1, 32'hFFFF_FC18, 32'd7);
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        cnt = 1;
        @(negedge clk);
        while (stallE === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        n_cmp++;
        if (cnt != DIV_STALL) begin
            n_fail++;
            $display("FAIL b2b_second_len got %0d want %0d", cnt, DIV_STALL);
        end
        @(posedge clk); #1;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL b2b_second_result got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        exp_t e;
        do_write(ALU_MTHI, 32'hAAAA_5555, 32'd0);
        do_write(ALU_MTLO, 32'h0F0F_F0F0, 32'd0);
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
        drive(ALU_DIV, 1'b1, 1'b0, 32'd50, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        drive(NOP, 1'b0, 1'b1, 32'd0, 32'd0);
        @(posedge clk); #1;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if (stallE !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall got %b want 0", stallE);
        end
        n_cmp++;
        if ({hi_o, lo_o} !== {e.hi, e.lo}) begin
            n_fail++;
            $display("FAIL flush_hold got %h_%h want %h_%h", hi_o, lo_o, e.hi, e.lo);
        end
        repeat (40) @(negedge clk);
        n_cmp++;
        if ({stallE, hi_o, lo_o} !== {1'b0, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL flush_late got stall=%b %h_%h want stall=0 %h_%h", stallE, hi_o, lo_o, m_hi, m_lo);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_div();
        do_write(ALU_MTHI, 32'h1111_2222, 32'd0);
        do_write(ALU_MTLO, 32'h3333_4444, 32'd0);
        drive(ALU_DIVU, 1'b1, 1'b0, 32'd12345, 32'd10);
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        n_cmp++;
        if ({stallE, hi_o, lo_o} !== {1'b0, m_hi, m_lo}) begin
            n_fail++;
            $display("FAIL rst_mid got stall=%b %h_%h want stall=0 0_0", stallE, hi_o, lo_o);
        end
        @(posedge clk); #1;
        drive(NOP, 1'b0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++;
        if ({stallE, hi_o, lo_o} !== 65'd0) begin
            n_fail++;
            $display("FAIL rst_no_partial got stall=%b %h_%h want stall=0 0_0", stallE, hi_o, lo_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_mult();
        test_mt_mf();
        test_div();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
